axi_4_req_arbiter: RTL and testbench
====================================

# axi_4_req_arbiter

Two-requester arbiter and burst sequencer in front of the AXI4 slave controller. It shares the single memory-side slave controller between two load/store requesters, such as a vector LSU and a scalar LSU. It grants one requester at a time with round-robin fairness and drives the controller's `ld_req`/`st_req` inputs. It also counts burst beats to generate the `s_rlast` and `wlast_done` indications the controller and memory need, and holds the grant until the AXI4 transaction fully completes.

## Interface
Parameters:
- `LEN_W`, default 8: width of the burst length field (AXI4 AxLEN, beats minus one).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low.
- `req0_ld`, `req0_st`  in  1 each  requester 0 load / store request; held until `done0`.
- `req0_len`  in  `LEN_W`  requester 0 burst length minus one; sampled at grant.
- `req1_ld`, `req1_st`, `req1_len`  in  1 / 1 / `LEN_W`  same for requester 1.
- `gnt0`, `gnt1`  out  1 each  requester currently owns the slave; one-hot or zero.
- `done0`, `done1`  out  1 each  one-cycle pulse on transaction completion.
- `ld_req`, `st_req`  out  1 each  to the slave controller; at most one high.
- `s_rvalid`, `m_rready`  in  1 each  read data channel handshake (monitored).
- `data_stored`  in  1  memory wrote one write beat.
- `s_bvalid`, `m_bready`  in  1 each  write response handshake (monitored).
- `s_rlast`  out  1  current read beat is the last one.
- `wlast_done`  out  1  current write beat is the last one.
- `beat_cnt`  out  `LEN_W`  index of the current beat within the burst.
- `busy`  out  1  a grant is active.

## Operation
- State machine with three states: `ARB_IDLE`, `ARB_READ`, `ARB_WRITE`. Reset enters `ARB_IDLE`.
- `ARB_IDLE` arbitration:
  - A requester is eligible if its `ld` or `st` is high.
  - If one requester is eligible, it wins.
  - If both are eligible, the requester not granted last wins. Round-robin pointer `last_gnt` resets to 1, so requester 0 wins first.
  - Within the winner, load beats store when both are high.
  - The winner's len is latched, `beat_cnt` clears to 0, `last_gnt` updates, and the next state is `ARB_READ` or `ARB_WRITE`.
- `ARB_READ`:
  - `ld_req`=1, `gnt` of owner =1.
  - A read beat completes on `s_rvalid && m_rready`, and `beat_cnt` increments.
  - `s_rlast` = (`beat_cnt` == len_q) while in `ARB_READ`.
  - Completion is `s_rvalid && m_rready && s_rlast`: pulse the owner's `done`, then go to `ARB_IDLE`.
- `ARB_WRITE`:
  - `st_req`=1, `gnt` of owner =1.
  - `data_stored` increments `beat_cnt` unless it equals len_q.
  - `wlast_done` = (`beat_cnt` == len_q) while in `ARB_WRITE`, combinational so it is valid in the same cycle as `data_stored`.
  - Completion is `s_bvalid && m_bready`: pulse `done`, then go to `ARB_IDLE`.
- `beat_cnt` saturates at len_q and never wraps. Extra beats past the last keep `s_rlast`/`wlast_done` high.
- Requests dropped mid-transaction are ignored. The grant is held until completion.
- The requester deasserts its request in the cycle after `done`. A request still high in `ARB_IDLE` is re-arbitrated normally.
- len_q = 0 means a single-beat burst: `s_rlast`/`wlast_done` are high from the first cycle.

## Timing
- Reset values:
  - `gnt0`/`gnt1`/`done0`/`done1`/`ld_req`/`st_req`/`busy`/`s_rlast`/`wlast_done` = 0.
  - `beat_cnt` = 0; `last_gnt` = 1; state `ARB_IDLE`.
- Reset asserted mid-burst aborts immediately with no `done` pulse.
- Outputs are decoded from registered state. `gnt`/`ld_req`/`st_req` rise 1 cycle after the request is seen in `ARB_IDLE`.
- `done` is registered. It is high for exactly the one cycle after the completing handshake, the same cycle the state returns to `ARB_IDLE` and `ld_req`/`st_req` fall.
- Minimum turnaround is one `ARB_IDLE` cycle between transactions. This matches the slave controller returning to `SLAVE_IDLE`.
- `beat_cnt` updates on the clock edge of the beat handshake. `s_rlast`/`wlast_done` follow combinationally from `beat_cnt`.

## Test plan
- Single read, requester 0 only:
  - Stimulus: `req0_ld`=1, `req0_len`=3, `m_rready`=1, `s_rvalid` every cycle.
  - Required response: `gnt0`/`ld_req` 1 cycle later; `s_rlast` high on the 4th beat; `done0` pulses once; `ld_req` low after.
- Contention:
  - Stimulus: both requesters assert `ld` at the same time, all lengths 0.
  - Required response: grants go 0, 1, 0, 1 across four consecutive transactions, with one idle cycle between each.
- Write with backpressure:
  - Stimulus: `req1_st`, len=2; `data_stored` on beats with gaps; `m_bready` delayed 3 cycles after `s_bvalid`.
  - Required response: `wlast_done` high only while `beat_cnt`=2; grant held until `s_bvalid && m_bready`; then `done1`.
- Load/store priority plus drop:
  - Stimulus: `req0_ld` and `req0_st` both high; `req0_ld` drops mid-burst.
  - Required response: load is served and completes normally; store is served next.
- Reset mid-burst:
  - Stimulus: assert `reset` at `beat_cnt`=1 of a len=3 read.
  - Required response: all outputs 0 immediately; no `done`; after release, requester 0 wins the first contention.

Source files
------------

// File: rtl/axi_4_req_arbiter.sv
// Two-requester round-robin arbiter and burst beat sequencer
// in front of the AXI4 slave controller.
module axi_4_req_arbiter #(
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_ld,
   input  logic             req0_st,
   input  logic [LEN_W-1:0] req0_len,
   input  logic             req1_ld,
   input  logic             req1_st,
   input  logic [LEN_W-1:0] req1_len,
   output logic             gnt0,
   output logic             gnt1,
   output logic             done0,
   output logic             done1,
   output logic             ld_req,
   output logic             st_req,
   input  logic             s_rvalid,
   input  logic             m_rready,
   input  logic             data_stored,
   input  logic             s_bvalid,
   input  logic             m_bready,
   output logic             s_rlast,
   output logic             wlast_done,
   output logic [LEN_W-1:0] beat_cnt,
   output logic             busy
);

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_READ,
      ARB_WRITE
   } arb_state_e;

   arb_state_e       state_q, state_d;
   logic             owner_q, owner_d;
   logic             last_gnt_q, last_gnt_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] beat_q, beat_d;
   logic             done0_q, done0_d;
   logic             done1_q, done1_d;

   logic elig0, elig1, win1, win_ld;
   logic at_last, rd_hs, wr_rsp;

   assign elig0   = req0_ld | req0_st;
   assign elig1   = req1_ld | req1_st;
   // last_gnt_q names the requester served last; the other one wins a tie
   assign win1    = elig1 & (~elig0 | ~last_gnt_q);
   assign win_ld  = win1 ? req1_ld : req0_ld;
   assign at_last = (beat_q == len_q);
   assign rd_hs   = s_rvalid & m_rready;
   assign wr_rsp  = s_bvalid & m_bready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ARB_IDLE;
         owner_q    <= 1'b0;
         last_gnt_q <= 1'b1;
         len_q      <= '0;
         beat_q     <= '0;
         done0_q    <= 1'b0;
         done1_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         last_gnt_q <= last_gnt_d;
         len_q      <= len_d;
         beat_q     <= beat_d;
         done0_q    <= done0_d;
         done1_q    <= done1_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      last_gnt_d = last_gnt_q;
      len_d      = len_q;
      beat_d     = beat_q;
      done0_d    = 1'b0;
      done1_d    = 1'b0;
      unique case (state_q)
         ARB_IDLE: begin
            if (elig0 | elig1) begin
               owner_d    = win1;
               last_gnt_d = win1;
               len_d      = win1 ? req1_len : req0_len;
               beat_d     = '0;
               state_d    = win_ld ? ARB_READ : ARB_WRITE;
            end
         end
         ARB_READ: begin
            if (rd_hs) begin
               if (!at_last) begin
                  beat_d = beat_q + LEN_W'(1);
               end else begin
                  state_d = ARB_IDLE;
                  done0_d = ~owner_q;
                  done1_d = owner_q;
               end
            end
         end
         ARB_WRITE: begin
            // count saturates so late beats keep wlast_done asserted
            if (data_stored && !at_last) begin
               beat_d = beat_q + LEN_W'(1);
            end
            if (wr_rsp) begin
               state_d = ARB_IDLE;
               done0_d = ~owner_q;
               done1_d = owner_q;
            end
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   assign busy       = (state_q != ARB_IDLE);
   assign gnt0       = busy & ~owner_q;
   assign gnt1       = busy & owner_q;
   assign ld_req     = (state_q == ARB_READ);
   assign st_req     = (state_q == ARB_WRITE);
   assign s_rlast    = ld_req & at_last;
   assign wlast_done = st_req & at_last;
   assign beat_cnt   = beat_q;
   assign done0      = done0_q;
   assign done1      = done1_q;

endmodule

// File: tb/tb_axi_4_req_arbiter.sv
// Scoreboard bench for axi_4_req_arbiter: grants and done pulses
// are checked by a monitor against queued expected transactions.
module tb_axi_4_req_arbiter;
   localparam int LEN_W = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             req0_ld, req0_st, req1_ld, req1_st;
   logic [LEN_W-1:0] req0_len, req1_len;
   logic             gnt0, gnt1, done0, done1;
   logic             ld_req, st_req;
   logic             s_rvalid, m_rready, data_stored;
   logic             s_bvalid, m_bready;
   logic             s_rlast, wlast_done, busy;
   logic [LEN_W-1:0] beat_cnt;

   axi_4_req_arbiter #(.LEN_W(LEN_W)) dut (
      .clk(clk), .reset(reset),
      .req0_ld(req0_ld), .req0_st(req0_st), .req0_len(req0_len),
      .req1_ld(req1_ld), .req1_st(req1_st), .req1_len(req1_len),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .ld_req(ld_req), .st_req(st_req),
      .s_rvalid(s_rvalid), .m_rready(m_rready),
      .data_stored(data_stored),
      .s_bvalid(s_bvalid), .m_bready(m_bready),
      .s_rlast(s_rlast), .wlast_done(wlast_done),
      .beat_cnt(beat_cnt), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic id;
      logic is_ld;
   } txn_t;

   txn_t exp_q[$];
   txn_t mt;
   int   n_cmp = 0;
   int   n_err = 0;
   int   n_gnt = 0;
   int   n_done = 0;
   logic cur_id = 1'b0;
   logic busy_prev = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      n_cmp++;
      n_err++;
      $display("FAIL %s: timed out waiting for DUT", nm);
   endtask

   // monitor: pop on each new grant, check owner on each done
   always @(negedge clk) begin
      if (!reset) begin
         busy_prev = 1'b0;
      end else begin
         if (busy && !busy_prev) begin
            n_gnt++;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_grant: gnt=%b%b", gnt1, gnt0);
            end else begin
               mt = exp_q.pop_front();
               chk("grant_owner", {30'd0, gnt1, gnt0}, mt.id ? 2 : 1);
               chk("grant_kind", {30'd0, ld_req, st_req}, mt.is_ld ? 2 : 1);
               cur_id = mt.id;
            end
         end
         if (done0 || done1) begin
            n_done++;
            chk("done_owner", {30'd0, done1, done0}, cur_id ? 2 : 1);
            chk("done_idle", {29'd0, busy, ld_req, st_req}, 0);
         end
         busy_prev = busy;
      end
   end

   task automatic wait_busy(input string nm);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (busy) return;
      end
      timeout(nm);
   endtask

   task automatic wait_done(input string nm);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (done0 || done1) return;
      end
      timeout(nm);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int   k;
      int   first;
      int   cnt;
      bit   got;
      logic ds_pat [7];

      reset = 1'b0;
      {req0_ld, req0_st, req1_ld, req1_st} = '0;
      req0_len = '0;
      req1_len = '0;
      {s_rvalid, m_rready, data_stored, s_bvalid, m_bready} = '0;
      repeat (2) @(negedge clk);
      chk("rst_gnt", {30'd0, gnt1, gnt0}, 0);
      chk("rst_done", {30'd0, done1, done0}, 0);
      chk("rst_req", {29'd0, busy, ld_req, st_req}, 0);
      chk("rst_last", {30'd0, s_rlast, wlast_done}, 0);
      chk("rst_beat", beat_cnt, 0);
      reset = 1'b1;
      @(negedge clk);

      // single read, requester 0, len 3
      req0_len = 8'd3;
      req0_ld  = 1'b1;
      m_rready = 1'b1;
      s_rvalid = 1'b1;
      exp_q.push_back('{id: 1'b0, is_ld: 1'b1});
      @(negedge clk);
      chk("t1_gnt0_latency", gnt0, 1);
      chk("t1_ldreq_latency", ld_req, 1);
      k = 0;
      first = -1;
      got = 0;
      for (int i = 0; i < 20; i++) begin
         if (done0) begin
            got = 1;
            break;
         end
         if (ld_req) begin
            if (s_rlast && first < 0) first = k;
            k++;
         end
         @(negedge clk);
      end
      chk("t1_rlast_beat", first, 3);
      chk("t1_beats", k, 4);
      chk("t1_done_seen", {31'd0, got}, 1);
      req0_ld  = 1'b0;
      s_rvalid = 1'b0;
      @(negedge clk);
      chk("t1_ldreq_after", ld_req, 0);
      chk("t1_done_once", done0, 0);

      // write with gapped beats and delayed bready, requester 1
      req1_len = 8'd2;
      req1_st  = 1'b1;
      exp_q.push_back('{id: 1'b1, is_ld: 1'b0});
      wait_busy("t2_grant");
      ds_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      cnt = 0;
      for (int i = 0; i < 7; i++) begin
         chk("t2_beat_cnt", beat_cnt, cnt);
         chk("t2_wlast", wlast_done, (cnt == 2) ? 1 : 0);
         data_stored = ds_pat[i];
         if (ds_pat[i] && cnt < 2) cnt++;
         @(negedge clk);
      end
      data_stored = 1'b0;
      chk("t2_wlast_sat", wlast_done, 1);
      s_bvalid = 1'b1;
      m_bready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("t2_gnt_hold", gnt1, 1);
         chk("t2_no_done", done1, 0);
      end
      m_bready = 1'b1;
      wait_done("t2_done");
      chk("t2_done1", done1, 1);
      req1_st  = 1'b0;
      s_bvalid = 1'b0;
      m_bready = 1'b0;
      @(negedge clk);

      // contention, all lengths 0
      req0_len = '0;
      req1_len = '0;
      req0_ld  = 1'b1;
      req1_ld  = 1'b1;
      m_rready = 1'b1;
      s_rvalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back('{id: i[0], is_ld: 1'b1});
      end
      for (int i = 0; i < 4; i++) begin
         wait_done("t3_done");
         chk("t3_order", {30'd0, done1, done0}, i[0] ? 2 : 1);
         if (i < 3) begin
            @(negedge clk);
            chk("t3_turnaround", busy, 1);
         end
      end
      req0_ld  = 1'b0;
      req1_ld  = 1'b0;
      s_rvalid = 1'b0;
      @(negedge clk);

      // load beats store within requester 0; load drops mid-burst
      req0_len = 8'd1;
      req0_ld  = 1'b1;
      req0_st  = 1'b1;
      exp_q.push_back('{id: 1'b0, is_ld: 1'b1});
      exp_q.push_back('{id: 1'b0, is_ld: 1'b0});
      wait_busy("t4_ld_grant");
      chk("t4_ld_first", ld_req, 1);
      req0_ld  = 1'b0;
      s_rvalid = 1'b1;
      wait_done("t4_ld_done");
      chk("t4_ld_done0", done0, 1);
      s_rvalid = 1'b0;
      wait_busy("t4_st_grant");
      chk("t4_st_next", st_req, 1);
      data_stored = 1'b1;
      repeat (2) @(negedge clk);
      chk("t4_wlast", wlast_done, 1);
      data_stored = 1'b0;
      s_bvalid = 1'b1;
      m_bready = 1'b1;
      wait_done("t4_st_done");
      chk("t4_st_done0", done0, 1);
      req0_st  = 1'b0;
      s_bvalid = 1'b0;
      m_bready = 1'b0;
      @(negedge clk);

      // reset mid-burst, then contention restarts at requester 0
      req0_len = 8'd3;
      req0_ld  = 1'b1;
      s_rvalid = 1'b1;
      exp_q.push_back('{id: 1'b0, is_ld: 1'b1});
      wait_busy("t5_grant");
      @(negedge clk);
      chk("t5_beat1", beat_cnt, 1);
      reset = 1'b0;
      #1;
      chk("t5_rst_gnt", {30'd0, gnt1, gnt0}, 0);
      chk("t5_rst_req", {29'd0, busy, ld_req, st_req}, 0);
      chk("t5_rst_beat", beat_cnt, 0);
      chk("t5_rst_rlast", s_rlast, 0);
      s_rvalid = 1'b0;
      req0_len = '0;
      req1_len = '0;
      req1_ld  = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("t5_no_done", {30'd0, done1, done0}, 0);
      end
      exp_q.push_back('{id: 1'b0, is_ld: 1'b1});
      exp_q.push_back('{id: 1'b1, is_ld: 1'b1});
      reset    = 1'b1;
      s_rvalid = 1'b1;
      wait_done("t5_first");
      chk("t5_first_winner", {30'd0, done1, done0}, 1);
      wait_done("t5_second");
      chk("t5_second_winner", {30'd0, done1, done0}, 2);
      req0_ld  = 1'b0;
      req1_ld  = 1'b0;
      s_rvalid = 1'b0;
      repeat (2) @(negedge clk);

      chk("queue_empty", exp_q.size(), 0);
      chk("grant_count", n_gnt, 11);
      chk("done_count", n_done, 10);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
